// File: rtl/game_pkg.sv
// Shared level codes and game states for the memory-game level encoder and decoder.
package game_pkg;

    typedef logic [1:0] level_t;

    localparam level_t LVL_OFF = 2'b00;
    localparam level_t LVL_1   = 2'b01;
    localparam level_t LVL_2   = 2'b10;
    localparam level_t LVL_3   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        WON  = 2'b10,
        OVER = 2'b11
    } state_t;

endpackage

// File: rtl/onehot_level_enc.sv
// One-hot start-level switches to level code; empty or multi-hot selections fall back to level 1.
module onehot_level_enc
    import game_pkg::*;
(
    input  logic [2:0] i_sel,
    output level_t     o_level
);

    // Encode the switch pattern
    always_comb begin
        o_level = LVL_1;
        case (i_sel)
            3'b001:  o_level = LVL_1;
            3'b010:  o_level = LVL_2;
            3'b100:  o_level = LVL_3;
            default: o_level = LVL_1;
        endcase
    end

endmodule

// File: rtl/level_encoder.sv
// Game-level sequencer: produces the registered 2-bit level code, round counter and game status.
module level_encoder
    import game_pkg::*;
#(
    parameter  int ROUNDS_PER_LEVEL = 3,
    localparam int CW = (ROUNDS_PER_LEVEL > 1) ? $clog2(ROUNDS_PER_LEVEL) : 1
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    start_sel,
    input  logic          round_win,
    input  logic          round_lose,
    input  logic          ack,
    output logic [1:0]    level,
    output logic          level_chg,
    output logic [CW-1:0] round_cnt,
    output logic          playing,
    output logic          game_won,
    output logic          game_over
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_LAST = CW'(ROUNDS_PER_LEVEL - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    state_t        r_state;
    state_t        w_state_nxt;
    level_t        r_level;
    level_t        w_level_nxt;
    level_t        w_enc_level;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_level_chg;
    logic          w_level_chg_nxt;
    logic          r_playing;
    logic          r_game_won;
    logic          r_game_over;
    logic          w_last_round;

    onehot_level_enc u_enc (
        .i_sel   (start_sel),
        .o_level (w_enc_level)
    );

    assign w_last_round = (r_cnt == CNT_LAST);

    // State and output registers; status flags are decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_level     <= LVL_OFF;
            r_cnt       <= CNT_ZERO;
            r_level_chg <= 1'b0;
            r_playing   <= 1'b0;
            r_game_won  <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_level     <= w_level_nxt;
            r_cnt       <= w_cnt_nxt;
            r_level_chg <= w_level_chg_nxt;
            r_playing   <= (w_state_nxt == PLAY);
            r_game_won  <= (w_state_nxt == WON);
            r_game_over <= (w_state_nxt == OVER);
        end
    end

    // Next-state logic; a simultaneous lose outranks a win
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = PLAY;
                else       w_state_nxt = IDLE;
            end
            PLAY: begin
                if (round_lose)
                    w_state_nxt = OVER;
                else if (round_win && w_last_round && (r_level == LVL_3))
                    w_state_nxt = WON;
                else
                    w_state_nxt = PLAY;
            end
            WON, OVER: begin
                if (ack) w_state_nxt = IDLE;
                else     w_state_nxt = r_state;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Level, round counter and change-pulse next values
    always_comb begin
        w_level_nxt     = r_level;
        w_cnt_nxt       = r_cnt;
        w_level_chg_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_level_nxt     = w_enc_level;
                    w_cnt_nxt       = CNT_ZERO;
                    w_level_chg_nxt = 1'b1;
                end else begin
                    w_level_nxt     = r_level;
                    w_cnt_nxt       = r_cnt;
                end
            end
            PLAY: begin
                if (round_lose) begin
                    w_level_nxt = r_level;
                    w_cnt_nxt   = r_cnt;
                end else if (round_win && !w_last_round) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end else if (round_win) begin
                    w_cnt_nxt = CNT_ZERO;
                    // Level 3 is final: no increment, so the code never wraps to off
                    if (r_level != LVL_3) begin
                        w_level_nxt     = r_level + 2'b01;
                        w_level_chg_nxt = 1'b1;
                    end else begin
                        w_level_nxt = r_level;
                    end
                end else begin
                    w_level_nxt = r_level;
                    w_cnt_nxt   = r_cnt;
                end
            end
            WON, OVER: begin
                if (ack) begin
                    w_level_nxt     = LVL_OFF;
                    w_cnt_nxt       = CNT_ZERO;
                    w_level_chg_nxt = 1'b1;
                end else begin
                    w_level_nxt = r_level;
                    w_cnt_nxt   = r_cnt;
                end
            end
            default: begin
                w_level_nxt = LVL_OFF;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    assign level     = r_level;
    assign level_chg = r_level_chg;
    assign round_cnt = r_cnt;
    assign playing   = r_playing;
    assign game_won  = r_game_won;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_level_encoder.sv
// Scoreboard bench for level_encoder: a behavioural game model queues expected outputs per cycle.
module tb_level_encoder;

    localparam int R  = 3;
    localparam int CW = 2;

    typedef struct packed {
        logic [1:0]    lvl;
        logic          chg;
        logic [CW-1:0] cnt;
        logic          ply;
        logic          won;
        logic          ovr;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [2:0]    start_sel;
    logic          round_win;
    logic          round_lose;
    logic          ack;
    logic [1:0]    level;
    logic          level_chg;
    logic [CW-1:0] round_cnt;
    logic          playing;
    logic          game_won;
    logic          game_over;

    int   n_pass;
    int   n_total;
    exp_t sb_q[$];

    // Behavioural model: 0 idle, 1 play, 2 won, 3 over
    int         m_state;
    logic [1:0] m_lvl;
    int         m_cnt;
    logic       m_chg;

    level_encoder #(.ROUNDS_PER_LEVEL(R)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_sel  (start_sel),
        .round_win  (round_win),
        .round_lose (round_lose),
        .ack        (ack),
        .level      (level),
        .level_chg  (level_chg),
        .round_cnt  (round_cnt),
        .playing    (playing),
        .game_won   (game_won),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] enc(input logic [2:0] sel);
        case (sel)
            3'b001:  return 2'b01;
            3'b010:  return 2'b10;
            3'b100:  return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model(input logic s, input logic [2:0] sel, input logic w,
                         input logic l, input logic a, input logic rs);
        m_chg = 1'b0;
        if (rs) begin
            m_state = 0; m_lvl = 2'b00; m_cnt = 0;
        end else begin
            case (m_state)
                0: if (s) begin
                    m_lvl = enc(sel); m_cnt = 0; m_chg = 1'b1; m_state = 1;
                end
                1: if (l) begin
                    m_state = 3;
                end else if (w) begin
                    if (m_cnt < R - 1) m_cnt = m_cnt + 1;
                    else begin
                        m_cnt = 0;
                        if (m_lvl == 2'b11) m_state = 2;
                        else begin m_lvl = m_lvl + 2'b01; m_chg = 1'b1; end
                    end
                end
                default: if (a) begin
                    m_state = 0; m_lvl = 2'b00; m_cnt = 0; m_chg = 1'b1;
                end
            endcase
        end
    endtask

    // Drive one cycle of inputs, queue the model's expectation, then compare once the DUT has registered it
    task automatic step(input logic s, input logic [2:0] sel, input logic w,
                        input logic l, input logic a, input logic rs);
        exp_t e;
        start = s; start_sel = sel; round_win = w; round_lose = l; ack = a; reset = rs;
        model(s, sel, w, l, a, rs);
        e.lvl = m_lvl; e.chg = m_chg; e.cnt = CW'(m_cnt);
        e.ply = (m_state == 1); e.won = (m_state == 2); e.ovr = (m_state == 3);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq("level",     {30'd0, level},     {30'd0, e.lvl});
            check_eq("level_chg", {31'd0, level_chg}, {31'd0, e.chg});
            check_eq("round_cnt", {30'd0, round_cnt}, {30'd0, e.cnt});
            check_eq("playing",   {31'd0, playing},   {31'd0, e.ply});
            check_eq("game_won",  {31'd0, game_won},  {31'd0, e.won});
            check_eq("game_over", {31'd0, game_over}, {31'd0, e.ovr});
        end
        start = 1'b0; round_win = 1'b0; round_lose = 1'b0; ack = 1'b0; reset = 1'b0;
    endtask

    task automatic idle_cycle();
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        m_state = 0; m_lvl = 2'b00; m_cnt = 0; m_chg = 1'b0;
        start = 1'b0; start_sel = 3'b000; round_win = 1'b0; round_lose = 1'b0;
        ack = 1'b0; reset = 1'b1;
        #2;

        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_level", {30'd0, level}, 32'd0);
        check_eq("rst_playing", {31'd0, playing}, 32'd0);
        // Inputs other than start do nothing while idle
        step(1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0);

        // Start at level 2
        step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("plan_l2_level", {30'd0, level}, 32'd2);
        check_eq("plan_l2_chg", {31'd0, level_chg}, 32'd1);
        idle_cycle();
        check_eq("plan_l2_chg_drop", {31'd0, level_chg}, 32'd0);
        step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);

        // Level 1 through to a won game, then ignored inputs, then ack
        step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("plan_won", {31'd0, game_won}, 32'd1);
        check_eq("plan_won_level", {30'd0, level}, 32'd3);
        step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);

        // Simultaneous win and lose at level 2 with one round banked
        step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("plan_over", {31'd0, game_over}, 32'd1);
        check_eq("plan_over_cnt", {30'd0, round_cnt}, 32'd1);
        // ack together with start only returns to idle
        step(1'b1, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("plan_ack_level", {30'd0, level}, 32'd0);
        idle_cycle();

        // Every start_sel pattern, with a stray start while playing
        for (int s = 0; s < 8; s++) begin
            step(1'b1, 3'(s), 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Reset mid-game at level 3 with two rounds banked
        step(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("plan_rst_mid", {30'd0, level}, 32'd0);
        step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random pulses
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
        end

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/level_encoder.md
Name: level_encoder

Overview:
- Sequential producer of the 2-bit level code that the memory-game level decoder consumes.
- Encodes the player's one-hot start-level selection into the 2-bit code: 00 = idle/off, 01 = level 1, 10 = level 2, 11 = level 3.
- Advances the code as rounds are won and freezes it on game over or game won.
- Sits between the round/compare logic (source of win/lose pulses) and the level decoder (consumer of the level code).

Parameters:
- ROUNDS_PER_LEVEL, 3, consecutive round wins required to leave a level; legal range 1..15.
- CW, $clog2(ROUNDS_PER_LEVEL) with a minimum of 1 (derived localparam), width of round_cnt.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a game from IDLE.
- start_sel  in  3  one-hot start-level switches; bit0 = L1, bit1 = L2, bit2 = L3.
- round_win  in  1  one-cycle pulse; the current round was won.
- round_lose  in  1  one-cycle pulse; the current round was lost.
- ack  in  1  one-cycle pulse; acknowledges the end of a game and returns to IDLE.
- level  out  2  registered level code for the decoder.
- level_chg  out  1  one-cycle pulse, high in the first cycle that `level` shows a new value.
- round_cnt  out  CW  rounds won so far in the current level.
- playing  out  1  high in state PLAY.
- game_won  out  1  high in state WON.
- game_over  out  1  high in state OVER.

Behaviour:
- Reset: state = IDLE, level = 00, round_cnt = 0, level_chg = 0, playing = 0, game_won = 0, game_over = 0. Reset mid-game aborts immediately; no pending pulse survives.
- All outputs are registered. An input event is reflected on the outputs exactly 1 cycle after the sampling edge.
- FSM states: IDLE, PLAY, WON, OVER. playing, game_won and game_over are Moore decodes of the state, registered.
- IDLE, on start:
  - level <= encode(start_sel): 001→01, 010→10, 100→11; 000 or any multi-hot value → 01.
  - round_cnt <= 0, level_chg <= 1, state → PLAY.
  - round_win, round_lose and ack are ignored in IDLE.
- PLAY:
  - round_lose → state OVER. Level is held, so the display keeps the failed level.
  - round_win with round_cnt < ROUNDS_PER_LEVEL-1 → round_cnt + 1.
  - round_win with round_cnt == ROUNDS_PER_LEVEL-1:
    - round_cnt <= 0.
    - If level != 11: level <= level + 1, level_chg <= 1.
    - If level == 11: state → WON with level held at 11. No increment, so no 11→00 wrap.
  - round_win and round_lose in the same cycle: lose wins; round_cnt is unchanged.
  - start and ack are ignored in PLAY.
- WON / OVER:
  - Outputs hold.
  - ack → state IDLE, level <= 00, round_cnt <= 0, level_chg <= 1.
  - start, round_win and round_lose are ignored.
  - ack and start in the same cycle: only ack acts. A new game needs a later start pulse.
- level_chg is high for exactly one cycle per level change and 0 otherwise. A start whose encoded level equals the previous level still pulses level_chg.
- Level arithmetic is 2-bit unsigned. Increment only ever happens from 01 or 10.
- ROUNDS_PER_LEVEL = 1: every round_win advances the level; round_cnt stays 0.

Decomposition:
- Shared package game_pkg holds:
  - the level_t typedef (logic [1:0]);
  - constants LVL_OFF = 2'b00, LVL_1 = 2'b01, LVL_2 = 2'b10, LVL_3 = 2'b11;
  - the state enum {IDLE, PLAY, WON, OVER}.
- The level decoder imports the same level constants.
- One natural sub-module: onehot_level_enc. It is a combinational 3-bit one-hot → level_t encoder with the fallback to LVL_1. It is instantiated once and is exhaustively testable.

Test Plan:
- Reset, then start with start_sel = 010 → after 1 cycle level = 10, level_chg = 1 for 1 cycle, playing = 1, round_cnt = 0.
- Start with start_sel = 001, then 3 round_win pulses (ROUNDS_PER_LEVEL = 3) → round_cnt goes 1, 2, then level = 10 with level_chg pulse and round_cnt = 0. 6 more wins → level = 11, then WON with game_won = 1 and level held at 11.
- In PLAY at level 10 with round_cnt = 1, assert round_win and round_lose together → game_over = 1, level = 10, round_cnt = 1. Then ack → level = 00, level_chg = 1, state IDLE.
- Start with start_sel = 000 and with 110 → level = 01 in both cases. Start pulsed during PLAY → no change.
- Reset asserted mid-game at level 11 with round_cnt = 2 → next cycle all outputs at reset values. round_win pulses then have no effect until start.
